// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and helpers for the programmable clock-enable divider
package clk_div_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int MIN_DIV = 2;
  // Cycles of div_out high per period; 32-bit so the +1 never overflows a DIV_W-bit ratio
  function automatic logic [31:0] high_len(input logic [31:0] n);
    return (n + 32'd1) >> 1;
  endfunction
endpackage

// File: rtl/div_counter_core.sv
// div_counter_core: period counter with registered divided waveform and tick
// Ports: load restarts a period at cnt=0 (start or wrap), run marks the RUN state,
// cur_div is the ratio in force; cnt/div_out/tick are registered, bnd flags the last cycle.
module div_counter_core import clk_div_pkg::*; #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic [DIV_W-1:0] cur_div,
  output logic [DIV_W-1:0] cnt,
  output logic             bnd,
  output logic             div_out,
  output logic             tick
);
  logic [DIV_W-1:0] cnt_inc;
  assign cnt_inc = cnt + DIV_W'(1);
  assign bnd = run && cnt == cur_div - DIV_W'(1);
  // Anything other than a restart or a mid-period advance parks the counter at zero
  always_ff @(posedge clk)
    if (rst || !(load || (run && !bnd))) begin
      cnt <= '0;
      div_out <= 1'b0;
      tick <= 1'b0;
    end else begin
      cnt <= load ? '0 : cnt_inc;
      div_out <= load || 32'(cnt_inc) < high_len(32'(cur_div));
      tick <= load;
    end
endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable divide-by-N controller with glitch-free ratio switching
// Ports: en requests running; cfg_valid/cfg_div/cfg_ready offer a new ratio, cfg_err pulses
// when an accepted ratio below 2 is discarded; div_out/tick/cnt describe the divided period,
// busy is high in RUN and cur_div is the ratio currently in force.
module clk_div_ctrl import clk_div_pkg::*; #(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_out,
  output logic             tick,
  output logic             busy,
  output logic [DIV_W-1:0] cur_div,
  output logic [DIV_W-1:0] cnt
);
  state_t state, state_nxt;
  logic pend_valid, pend_valid_nxt, accept, good, bnd, load, run;
  logic [DIV_W-1:0] pend_div, pend_div_nxt, cur_nxt;
  assign run = state == RUN;
  assign busy = run;
  assign cfg_ready = !pend_valid;
  assign accept = cfg_valid && cfg_ready;
  assign good = accept && cfg_div >= DIV_W'(MIN_DIV);
  assign load = en && (!run || bnd);
  // Ratios only change while idle or on the last cycle of a period; mid-period offers wait in pend
  always_comb begin
    state_nxt = run ? (bnd && !en ? IDLE : RUN) : (en ? RUN : IDLE);
    cur_nxt = run && bnd && pend_valid ? pend_div : good && (!run || bnd) ? cfg_div : cur_div;
    pend_valid_nxt = run && !bnd && (pend_valid || good);
    pend_div_nxt = good ? cfg_div : pend_div;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      pend_valid <= 1'b0;
      pend_div <= '0;
      cur_div <= DIV_W'(DEF_DIV);
      cfg_err <= 1'b0;
    end else begin
      state <= state_nxt;
      pend_valid <= pend_valid_nxt;
      pend_div <= pend_div_nxt;
      cur_div <= cur_nxt;
      cfg_err <= accept && !good;
    end
  div_counter_core #(.DIV_W(DIV_W)) u_core (
    .clk(clk), .rst(rst), .load(load), .run(run), .cur_div(cur_div),
    .cnt(cnt), .bnd(bnd), .div_out(div_out), .tick(tick)
  );
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: table vectors, corner sequences and random stimulus against a period-level model
module tb_clk_div_ctrl;
  logic clk = 0, rst = 1, en = 0, cfg_valid = 0;
  logic [7:0] cfg_div = 0;
  logic cfg_ready, cfg_err, div_out, tick, busy;
  logic [7:0] cur_div, cnt;
  int vectors = 0, miscompares = 0;
  int m_run, m_pos, m_cur, m_pv, m_pd, m_err;
  typedef struct {
    logic r, e, v;
    logic [7:0] d, cnt;
    logic dv, tk, bz;
    logic [7:0] cur;
    logic rdy, err;
  } vec_t;
  vec_t tbl[18];

  clk_div_ctrl #(.DIV_W(8), .DEF_DIV(5)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .div_out(div_out), .tick(tick),
    .busy(busy), .cur_div(cur_div), .cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic r, e, v, input logic [7:0] d);
    @(negedge clk);
    rst = r; en = e; cfg_valid = v; cfg_div = d;
  endtask

  task automatic check(input string name, input logic [20:0] exp);
    logic [20:0] act;
    act = {cnt, div_out, tick, busy, cur_div, cfg_ready, cfg_err};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got cnt=%0d div=%b tick=%b busy=%b cur=%0d rdy=%b err=%b, want cnt=%0d div=%b tick=%b busy=%b cur=%0d rdy=%b err=%b",
               name, act[20:13], act[12], act[11], act[10], act[9:2], act[1], act[0],
               exp[20:13], exp[12], exp[11], exp[10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  // Model: period position and ratio bookkeeping; outputs follow from position and ratio
  task automatic model(input logic r, e, v, input logic [7:0] d);
    int acc, ok, last;
    if (r) begin
      m_run = 0; m_pos = 0; m_cur = 5; m_pv = 0; m_pd = 0; m_err = 0;
      return;
    end
    acc = v && !m_pv;
    ok = acc && d >= 2;
    last = m_run && m_pos == m_cur - 1;
    m_err = acc && !ok;
    if (!m_run) begin
      if (ok) m_cur = d;
      if (e) begin m_run = 1; m_pos = 0; end
    end else if (last) begin
      if (m_pv) m_cur = m_pd; else if (ok) m_cur = d;
      m_pv = 0; m_pos = 0; m_run = e;
    end else begin
      m_pos++;
      if (ok) begin m_pv = 1; m_pd = d; end
    end
  endtask

  task automatic step(input string name, input logic r, e, v, input logic [7:0] d);
    logic [20:0] exp;
    drive(r, e, v, d);
    model(r, e, v, d);
    @(posedge clk); #1;
    exp = {8'(m_pos), 1'(m_run && m_pos < (m_cur + 1) / 2), 1'(m_run && m_pos == 0),
           1'(m_run), 8'(m_cur), 1'(!m_pv), 1'(m_err)};
    check(name, exp);
  endtask

  initial begin
    //          r  e  v  d    cnt dv tk bz cur rdy err
    tbl[0]  = '{1, 0, 0, 0,   0,  0, 0, 0, 5,  1,  0};
    tbl[1]  = '{0, 1, 0, 0,   0,  1, 1, 1, 5,  1,  0};
    tbl[2]  = '{0, 1, 0, 0,   1,  1, 0, 1, 5,  1,  0};
    tbl[3]  = '{0, 1, 1, 4,   2,  1, 0, 1, 5,  0,  0};
    tbl[4]  = '{0, 1, 0, 0,   3,  0, 0, 1, 5,  0,  0};
    tbl[5]  = '{0, 1, 0, 0,   4,  0, 0, 1, 5,  0,  0};
    tbl[6]  = '{0, 1, 0, 0,   0,  1, 1, 1, 4,  1,  0};
    tbl[7]  = '{0, 1, 0, 0,   1,  1, 0, 1, 4,  1,  0};
    tbl[8]  = '{0, 1, 0, 0,   2,  0, 0, 1, 4,  1,  0};
    tbl[9]  = '{0, 1, 1, 1,   3,  0, 0, 1, 4,  1,  1};
    tbl[10] = '{0, 1, 1, 0,   0,  1, 1, 1, 4,  1,  1};
    tbl[11] = '{0, 0, 0, 0,   1,  1, 0, 1, 4,  1,  0};
    tbl[12] = '{0, 0, 0, 0,   2,  0, 0, 1, 4,  1,  0};
    tbl[13] = '{0, 0, 0, 0,   3,  0, 0, 1, 4,  1,  0};
    tbl[14] = '{0, 0, 0, 0,   0,  0, 0, 0, 4,  1,  0};
    tbl[15] = '{0, 0, 1, 7,   0,  0, 0, 0, 7,  1,  0};
    tbl[16] = '{0, 1, 0, 0,   0,  1, 1, 1, 7,  1,  0};
    tbl[17] = '{1, 1, 0, 0,   0,  0, 0, 0, 5,  1,  0};
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].d);
      @(posedge clk); #1;
      check($sformatf("table[%0d]", i), {tbl[i].cnt, tbl[i].dv, tbl[i].tk, tbl[i].bz,
                                         tbl[i].cur, tbl[i].rdy, tbl[i].err});
    end
    // Default ratio, then ratio 2 offered exactly on the boundary takes effect immediately
    step("rst_a", 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step("def5", 0, 1, 0, 0);
    step("bnd_cfg2", 0, 1, 1, 2);
    for (int i = 0; i < 6; i++) step("div2", 0, 1, 0, 0);
    // Back to 5, then invalid ratios mid-period
    step("cfg5", 0, 1, 1, 5);
    for (int i = 0; i < 3; i++) step("to5", 0, 1, 0, 0);
    step("err1", 0, 1, 1, 1);
    step("err0", 0, 1, 1, 0);
    for (int i = 0; i < 6; i++) step("post_err", 0, 1, 0, 0);
    // en dropped mid-period: period completes, then idle, then restart
    step("rst_b", 1, 0, 0, 0);
    step("start", 0, 1, 0, 0);
    step("cnt1", 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step("drain", 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step("restart", 0, 1, 0, 0);
    // en glitch before the boundary continues seamlessly
    step("glitch", 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step("seamless", 0, 1, 0, 0);
    // Reset with a pending ratio drops it
    step("rst_c", 1, 0, 0, 0);
    step("p_start", 0, 1, 0, 0);
    step("p_cnt1", 0, 1, 1, 3);
    step("p_rst", 1, 1, 0, 0);
    for (int i = 0; i < 11; i++) step("after_rst", 0, 1, 0, 0);
    // Maximum ratio 255
    step("rst_d", 1, 0, 0, 0);
    step("cfg255", 0, 0, 1, 255);
    for (int i = 0; i < 520; i++) step("div255", 0, 1, 0, 0);
    // Random stimulus
    step("rst_e", 1, 0, 0, 0);
    for (int i = 0; i < 4000; i++)
      step("random", $urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 3) == 0, 8'($urandom_range(0, 9)));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
